adc_acquire: RTL and testbench
==============================

# adc_acquire

Serial-ADC front end that drives a 16-bit SPI-style ADC, captures conversions, and optionally averages a power-of-two number of them. It produces the `adc_data` word consumed directly by the temperature calculation stage, with a one-cycle `adc_valid` strobe. One acquisition is launched per `start` pulse.

## Interface
- `CLK_DIV`, default 4: `clk` cycles per `adc_sclk` half-period; legal values are ≥1.
- `AVG_LOG2`, default 2: log2 of the number of conversions averaged; legal range 0..4.
- `clk`  in  1  system clock, single clock domain; all logic is on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  acquisition request, sampled only in IDLE.
- `busy`  out  1  high from the cycle after an accepted `start` through the `adc_valid` cycle.
- `adc_cs_n`  out  1  ADC chip select, active low.
- `adc_sclk`  out  1  ADC serial clock; idles low.
- `adc_sdo`  in  1  ADC serial data, MSB first, stable around the `adc_sclk` rising edge.
- `adc_data`  out  16  averaged conversion result; holds its value until the next `adc_valid`.
- `adc_valid`  out  1  one-cycle pulse marking a new `adc_data`.

## Operation
- Reset values of all outputs:
  - `busy`=0, `adc_cs_n`=1, `adc_sclk`=0, `adc_data`=16'h0000, `adc_valid`=0.
  - Accumulator, counters and FSM are cleared.
- FSM states: IDLE → CS_SETUP → SHIFT → CS_HOLD → (CS_SETUP again, or DONE) → IDLE.
- IDLE: `start`=1 moves the FSM to CS_SETUP and sets `busy`.
- CS_SETUP: `adc_cs_n` is low and `adc_sclk` is low for CLK_DIV cycles.
- SHIFT: 16 `adc_sclk` periods, each CLK_DIV cycles low then CLK_DIV cycles high.
  - `adc_sdo` is sampled on the `clk` edge where `adc_sclk` rises.
  - Bits are shifted into bit 0 of a 16-bit shift register, MSB first.
- CS_HOLD: `adc_cs_n` is high for CLK_DIV cycles, then the captured word is added to the accumulator.
  - If the conversion count is below 2^AVG_LOG2, the FSM goes to CS_SETUP; otherwise it goes to DONE.
- DONE (one cycle):
  - `adc_data` = accumulator >> AVG_LOG2, truncated, never rounded.
  - `adc_valid`=1.
  - Accumulator and count are cleared; the FSM returns to IDLE with `busy`=0 on the next cycle.
- Accumulator width is 16+AVG_LOG2, so it cannot overflow. The all-ones input averages to 16'hFFFF.
- `start` while `busy`: ignored, no queuing.
- `start` in the same cycle as DONE: ignored, because the FSM is not in IDLE.
- `rst` mid-acquisition: immediate return to the reset values.
  - `adc_data` is also cleared; the partial sum is discarded.

## Timing
- One conversion lasts 34·CLK_DIV cycles: setup CLK_DIV + shift 32·CLK_DIV + hold CLK_DIV.
- With `start` high at edge k:
  - `adc_cs_n` falls at edge k+1.
  - `adc_valid` is high in cycle k+1+34·CLK_DIV·2^AVG_LOG2.
- Back-to-back acquisitions: the earliest next accepted `start` is the cycle after `adc_valid`.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- `ADC_AVG_EN` defined: averaging as described above.
- `ADC_AVG_EN` undefined:
  - AVG_LOG2 is ignored and treated as 0; the accumulator is not instantiated.
  - DONE follows the first CS_HOLD, and `adc_data` = the raw captured word.
  - Latency is k+1+34·CLK_DIV.

## Structure
- Package `adc_pkg` holds:
  - The state enum (IDLE, CS_SETUP, SHIFT, CS_HOLD, DONE).
  - `ADC_BITS`=16.
  - The maximum AVG_LOG2 = 4.
- Sub-module `adc_serial_rx` performs one conversion (CS_SETUP/SHIFT/CS_HOLD timing, shift register, `done` pulse).
- `adc_acquire` contains the top-level FSM, conversion counter, accumulator and output registers.

## Test plan
- CLK_DIV=2, AVG_LOG2=2, ADC model returns 16'h0017 four times → `adc_data`=16'h0017, `adc_valid` exactly at k+273, `busy` high for 273 cycles.
- ADC returns 10, 11, 12, 13 → sum 46, `adc_data`=16'd11 (truncation).
- ADC returns 16'hFFFF four times → `adc_data`=16'hFFFF, no wrap.
- `start` pulsed at k+50 during an acquisition → ignored; exactly one `adc_valid`, and `adc_cs_n` shows exactly 4 low windows.
- `rst` asserted during the 8th SHIFT bit → next cycle `adc_cs_n`=1, `adc_sclk`=0, `adc_data`=0; a new `start` then produces a correct result.
- `ADC_AVG_EN` undefined, CLK_DIV=2, ADC returns 16'h00AB → `adc_data`=16'h00AB at k+69, one `adc_cs_n` low window.

Source files
------------

// File: rtl/adc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : adc_pkg
//  Description : Shared constants, state encodings and helpers for the serial
//                ADC acquisition front end (adc_acquire / adc_serial_rx).
//  Contents    : ADC_BITS      - conversion word width
//                AVG_LOG2_MAX  - largest supported averaging exponent
//                adc_state_t   - per-conversion serial phase encoding
//                acq_state_t   - top-level acquisition sequencer encoding
//                cnt_width()   - counter width helper, never returns 0
//  Revision    : 1.0 - initial release
// ============================================================================
package adc_pkg;

    localparam int unsigned ADC_BITS     = 16;
    localparam int unsigned AVG_LOG2_MAX = 4;

    // Serial phases of one conversion; ST_DONE is the acquisition-complete
    // phase shared in naming with the top-level sequencer.
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_CS_SETUP = 3'd1,
        ST_SHIFT    = 3'd2,
        ST_CS_HOLD  = 3'd3,
        ST_DONE     = 3'd4
    } adc_state_t;

    // Top-level sequencer: idle, conversions in flight, one-cycle result.
    typedef enum logic [1:0] {
        ACQ_IDLE = 2'd0,
        ACQ_RUN  = 2'd1,
        ACQ_DONE = 2'd2
    } acq_state_t;

    // Width of a counter that must hold 0..n-1; at least one bit so that
    // CLK_DIV=1 still yields a legal vector.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage : adc_pkg
`default_nettype wire

// File: rtl/adc_serial_rx.sv
`default_nettype none
// ============================================================================
//  Module      : adc_serial_rx
//  Description : Performs one 16-bit SPI-style ADC conversion: chip-select
//                setup, 16 serial clock periods with MSB-first capture, and
//                chip-select hold. A new conversion may be chained directly
//                from the last hold cycle without returning to idle.
//  Parameters  : CLK_DIV  - clk cycles per sclk half-period (>=1)
//  Ports       : clk, rst   - clock, asynchronous active-high reset
//                i_start    - launch a conversion (idle or last hold cycle)
//                i_sdo      - ADC serial data
//                o_cs_n     - chip select, active low (registered)
//                o_sclk     - serial clock, idles low (registered)
//                o_done     - high during the last hold cycle
//                o_data     - captured word, valid while o_done is high
//  Revision    : 1.0 - initial release
// ============================================================================
module adc_serial_rx
    import adc_pkg::*;
#(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_start,
    input  logic                i_sdo,
    output logic                o_cs_n,
    output logic                o_sclk,
    output logic                o_done,
    output logic [ADC_BITS-1:0] o_data
);

    localparam int unsigned         c_CNT_W    = cnt_width(CLK_DIV);
    localparam logic [c_CNT_W-1:0]  c_CNT_LAST = c_CNT_W'(CLK_DIV - 1);
    localparam int unsigned         c_BIT_W    = $clog2(ADC_BITS);
    localparam logic [c_BIT_W-1:0]  c_BIT_LAST = c_BIT_W'(ADC_BITS - 1);

    adc_state_t           r_state;
    adc_state_t           w_state_nxt;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [c_BIT_W-1:0]   r_bit;
    logic                 r_cs_n;
    logic                 r_sclk;
    logic [ADC_BITS-1:0]  r_shift;
    logic                 w_cnt_last;

    assign w_cnt_last = (r_cnt == c_CNT_LAST);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    w_state_nxt = ST_CS_SETUP;
                end
            end
            ST_CS_SETUP: begin
                if (w_cnt_last) begin
                    w_state_nxt = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                // Leave after the high half of the final bit period.
                if (w_cnt_last && r_sclk && (r_bit == c_BIT_LAST)) begin
                    w_state_nxt = ST_CS_HOLD;
                end
            end
            ST_CS_HOLD: begin
                if (w_cnt_last) begin
                    w_state_nxt = i_start ? ST_CS_SETUP : ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Timing counters, serial clock and shift register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt   <= '0;
            r_bit   <= '0;
            r_cs_n  <= 1'b1;
            r_sclk  <= 1'b0;
            r_shift <= '0;
        end else begin
            // Chip select follows the next state so it moves on the same
            // edge the phase changes, keeping the output registered.
            r_cs_n <= !((w_state_nxt == ST_CS_SETUP) || (w_state_nxt == ST_SHIFT));

            case (r_state)
                ST_SHIFT: begin
                    r_cnt <= w_cnt_last ? '0 : r_cnt + c_CNT_W'(1);
                    if (w_cnt_last) begin
                        r_sclk <= ~r_sclk;
                        if (!r_sclk) begin
                            // sclk rises on this edge: capture the data bit.
                            r_shift <= {r_shift[ADC_BITS-2:0], i_sdo};
                        end else begin
                            r_bit <= r_bit + c_BIT_W'(1);
                        end
                    end
                end
                ST_CS_SETUP, ST_CS_HOLD: begin
                    r_cnt  <= w_cnt_last ? '0 : r_cnt + c_CNT_W'(1);
                    r_sclk <= 1'b0;
                    r_bit  <= '0;
                end
                default: begin
                    r_cnt  <= '0;
                    r_sclk <= 1'b0;
                    r_bit  <= '0;
                end
            endcase
        end
    end

    assign o_cs_n = r_cs_n;
    assign o_sclk = r_sclk;
    assign o_done = (r_state == ST_CS_HOLD) && w_cnt_last;
    assign o_data = r_shift;

endmodule : adc_serial_rx
`default_nettype wire

// File: rtl/adc_acquire.sv
`default_nettype none
// ============================================================================
//  Module      : adc_acquire
//  Description : Serial-ADC front end. Each accepted start runs 2^AVG_LOG2
//                back-to-back conversions, sums them and presents the
//                truncated mean on adc_data with a one-cycle adc_valid.
//  Build macro : ADC_AVG_EN - when defined, averaging is enabled; when
//                undefined, AVG_LOG2 is ignored, no accumulator exists and a
//                single raw conversion is reported.
//  Parameters  : CLK_DIV  - clk cycles per adc_sclk half-period (>=1)
//                AVG_LOG2 - log2 of conversions averaged (0..4)
//  Ports       : clk, rst    - clock, asynchronous active-high reset
//                start       - acquisition request, honoured only when idle
//                busy        - acquisition in progress (through valid cycle)
//                adc_cs_n    - ADC chip select, active low
//                adc_sclk    - ADC serial clock, idles low
//                adc_sdo     - ADC serial data, MSB first
//                adc_data    - result word, held until next adc_valid
//                adc_valid   - one-cycle result strobe
//  Revision    : 1.0 - initial release
// ============================================================================
module adc_acquire
    import adc_pkg::*;
#(
    parameter int unsigned CLK_DIV  = 4,
    parameter int unsigned AVG_LOG2 = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    output logic                busy,
    output logic                adc_cs_n,
    output logic                adc_sclk,
    input  logic                adc_sdo,
    output logic [ADC_BITS-1:0] adc_data,
    output logic                adc_valid
);

    acq_state_t           r_state;
    acq_state_t           w_state_nxt;
    logic                 w_rx_start;
    logic                 w_rx_done;
    logic [ADC_BITS-1:0]  w_rx_data;
    logic                 w_last;
    logic [ADC_BITS-1:0]  w_result;
    logic                 r_busy;
    logic                 r_valid;
    logic [ADC_BITS-1:0]  r_data;

    // ------------------------------------------------------------------
    // One-conversion serial engine
    // ------------------------------------------------------------------
    adc_serial_rx #(
        .CLK_DIV (CLK_DIV)
    ) u_rx (
        .clk     (clk),
        .rst     (rst),
        .i_start (w_rx_start),
        .i_sdo   (adc_sdo),
        .o_cs_n  (adc_cs_n),
        .o_sclk  (adc_sclk),
        .o_done  (w_rx_done),
        .o_data  (w_rx_data)
    );

`ifdef ADC_AVG_EN
    // ------------------------------------------------------------------
    // Averaging: conversion counter and accumulator. The accumulator is
    // ADC_BITS+log2 wide, so the all-ones sum never wraps.
    // ------------------------------------------------------------------
    localparam int unsigned c_AVG_LOG2  = (AVG_LOG2 > AVG_LOG2_MAX) ? AVG_LOG2_MAX : AVG_LOG2;
    localparam int unsigned c_ACC_W     = ADC_BITS + c_AVG_LOG2;
    localparam int unsigned c_CONV_W    = c_AVG_LOG2 + 1;
    localparam logic [c_CONV_W-1:0] c_CONV_LAST = c_CONV_W'((1 << c_AVG_LOG2) - 1);

    logic [c_ACC_W-1:0]   r_acc;
    logic [c_ACC_W-1:0]   w_sum;
    logic [c_CONV_W-1:0]  r_conv;

    // The word finishing this cycle is folded in combinationally so the
    // result register can load the complete sum on the same edge.
    assign w_sum    = r_acc + c_ACC_W'(w_rx_data);
    assign w_last   = (r_conv == c_CONV_LAST);
    assign w_result = w_sum[c_ACC_W-1:c_AVG_LOG2];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc  <= '0;
            r_conv <= '0;
        end else if (w_rx_done) begin
            if (w_last) begin
                r_acc  <= '0;
                r_conv <= '0;
            end else begin
                r_acc  <= w_sum;
                r_conv <= r_conv + c_CONV_W'(1);
            end
        end
    end
`else
    // Single raw conversion per acquisition.
    assign w_last   = 1'b1;
    assign w_result = w_rx_data;
`endif

    // ------------------------------------------------------------------
    // Acquisition sequencer: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ACQ_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Acquisition sequencer: next state and conversion launch
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_rx_start  = 1'b0;
        case (r_state)
            ACQ_IDLE: begin
                if (start) begin
                    w_state_nxt = ACQ_RUN;
                    w_rx_start  = 1'b1;
                end
            end
            ACQ_RUN: begin
                if (w_rx_done) begin
                    if (w_last) begin
                        w_state_nxt = ACQ_DONE;
                    end else begin
                        // Chain the next conversion straight out of hold.
                        w_rx_start = 1'b1;
                    end
                end
            end
            ACQ_DONE: begin
                // start is deliberately not examined here.
                w_state_nxt = ACQ_IDLE;
            end
            default: begin
                w_state_nxt = ACQ_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy  <= 1'b0;
            r_valid <= 1'b0;
            r_data  <= '0;
        end else begin
            r_busy  <= (w_state_nxt != ACQ_IDLE);
            r_valid <= (w_state_nxt == ACQ_DONE);
            if ((r_state == ACQ_RUN) && w_rx_done && w_last) begin
                r_data <= w_result;
            end
        end
    end

    assign busy      = r_busy;
    assign adc_valid = r_valid;
    assign adc_data  = r_data;

endmodule : adc_acquire
`default_nettype wire

// File: tb/tb_adc_acquire.sv
`default_nettype none
// ============================================================================
//  Module      : tb_adc_acquire
//  Description : Directed self-checking bench for adc_acquire with a
//                behavioural serial ADC that returns a per-test word table.
//                Expected values follow the ADC_AVG_EN build setting.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_adc_acquire;

    localparam int CLK_DIV  = 2;
    localparam int AVG_LOG2 = 2;
`ifdef ADC_AVG_EN
    localparam int N_CONV = 4;
    localparam logic [15:0] c_EXP_SEQ  = 16'd11;   // (10+11+12+13)>>2
    localparam logic [15:0] c_EXP_SMALL = 16'd2;   // (1+2+3+4)>>2
    localparam logic [15:0] c_EXP_POST = 16'd250;  // (100+200+300+400)>>2
`else
    localparam int N_CONV = 1;
    localparam logic [15:0] c_EXP_SEQ  = 16'd10;
    localparam logic [15:0] c_EXP_SMALL = 16'd1;
    localparam logic [15:0] c_EXP_POST = 16'd100;
`endif
    localparam int c_LAT = 1 + 34 * CLK_DIV * N_CONV;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        busy;
    logic        adc_cs_n;
    logic        adc_sclk;
    logic        adc_sdo;
    logic [15:0] adc_data;
    logic        adc_valid;

    always #5 clk = ~clk;

    adc_acquire #(
        .CLK_DIV  (CLK_DIV),
        .AVG_LOG2 (AVG_LOG2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .busy      (busy),
        .adc_cs_n  (adc_cs_n),
        .adc_sclk  (adc_sclk),
        .adc_sdo   (adc_sdo),
        .adc_data  (adc_data),
        .adc_valid (adc_valid)
    );

    // ------------------------------------------------------------------
    // Cycle counter and event counters
    // ------------------------------------------------------------------
    int cyc = 0;
    int nvalid = 0;
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (adc_valid) nvalid <= nvalid + 1;
    end

    // ------------------------------------------------------------------
    // Serial ADC model: new word on each chip-select fall, MSB first,
    // advancing one bit after every sclk rising edge.
    // ------------------------------------------------------------------
    logic [15:0] words [4];
    logic [15:0] cur_word = 16'h0000;
    int cs_fall = 0;
    int base_fall = 0;
    int nrise = 0;
    int rise_base = 0;
    int bit_k;

    always @(negedge adc_cs_n) begin
        cur_word  = words[(cs_fall - base_fall) % 4];
        cs_fall   = cs_fall + 1;
        rise_base = nrise;
    end

    always @(posedge adc_sclk) nrise = nrise + 1;

    always_comb begin
        bit_k   = nrise - rise_base;
        adc_sdo = 1'b0;
        if (bit_k >= 0 && bit_k < 16) adc_sdo = cur_word[15 - bit_k];
    end

    // ------------------------------------------------------------------
    // Checking
    // ------------------------------------------------------------------
    int n_chk = 0;
    int n_fail = 0;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic load_words(input logic [15:0] w0, input logic [15:0] w1,
                              input logic [15:0] w2, input logic [15:0] w3);
        words[0]  = w0;
        words[1]  = w1;
        words[2]  = w2;
        words[3]  = w3;
        base_fall = cs_fall;
    endtask

    // One acquisition; optional extra start pulse extra_at cycles after k.
    task automatic run_acq(input string tag, input logic [15:0] exp_data, input int extra_at);
        int k;
        int lat;
        int busy_n;
        int cs0;
        int v0;
        bit got;
        cs0    = cs_fall;
        v0     = nvalid;
        busy_n = 0;
        got    = 1'b0;
        lat    = -1;
        @(posedge clk); #1;
        k     = cyc;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk_eq({tag, "_cs_fall"}, adc_cs_n, 1'b0);
        for (int i = 0; i < c_LAT + 20 && !got; i++) begin
            if (busy) busy_n++;
            if (adc_valid) begin
                got = 1'b1;
                lat = cyc - k;
                chk_eq({tag, "_data"}, adc_data, exp_data);
            end
            start = (extra_at > 0) && (cyc - k == extra_at);
            if (!got) begin
                @(posedge clk); #1;
            end
        end
        start = 1'b0;
        chk_eq({tag, "_latency"}, lat, c_LAT);
        chk_eq({tag, "_busy_cycles"}, busy_n, c_LAT);
        @(posedge clk); #1;
        chk_eq({tag, "_busy_clr"}, busy, 1'b0);
        chk_eq({tag, "_valid_clr"}, adc_valid, 1'b0);
        chk_eq({tag, "_data_hold"}, adc_data, exp_data);
        chk_eq({tag, "_cs_windows"}, cs_fall - cs0, N_CONV);
        // Let any wrongly accepted second acquisition show itself.
        repeat (c_LAT + 5) @(posedge clk);
        #1;
        chk_eq({tag, "_valid_count"}, nvalid - v0, 1);
    endtask

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        int k;
        load_words(16'h0, 16'h0, 16'h0, 16'h0);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk_eq("rst_busy",  busy,      1'b0);
        chk_eq("rst_cs_n",  adc_cs_n,  1'b1);
        chk_eq("rst_sclk",  adc_sclk,  1'b0);
        chk_eq("rst_data",  adc_data,  16'h0000);
        chk_eq("rst_valid", adc_valid, 1'b0);
        rst = 1'b0;

        load_words(16'h0017, 16'h0017, 16'h0017, 16'h0017);
        run_acq("const", 16'h0017, 0);

        load_words(16'd10, 16'd11, 16'd12, 16'd13);
        run_acq("trunc", c_EXP_SEQ, 0);

        load_words(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);
        run_acq("ones", 16'hFFFF, 0);

        load_words(16'd1, 16'd2, 16'd3, 16'd4);
        run_acq("busy_start", c_EXP_SMALL, 50);

        // Reset in the middle of the 8th serial bit (cycles k+31..k+34).
        load_words(16'h5555, 16'h5555, 16'h5555, 16'h5555);
        @(posedge clk); #1;
        k     = cyc;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        while (cyc - k < 32) begin
            @(posedge clk); #1;
        end
        chk_eq("pre_rst_cs_n", adc_cs_n, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        chk_eq("mid_rst_cs_n", adc_cs_n, 1'b1);
        chk_eq("mid_rst_sclk", adc_sclk, 1'b0);
        chk_eq("mid_rst_data", adc_data, 16'h0000);
        chk_eq("mid_rst_busy", busy,     1'b0);
        rst = 1'b0;
        @(posedge clk); #1;

        load_words(16'd100, 16'd200, 16'd300, 16'd400);
        run_acq("post_rst", c_EXP_POST, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_adc_acquire
`default_nettype wire
